// File: rtl/ervp_axi_sram_responder_if.sv
// ============================================================================
// Module   : ervp_axi_sram_responder_if
// Purpose  : AXI AW/W/B/AR/R bundle between a master and the SRAM responder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef BW_AXI_ALEN
`define BW_AXI_ALEN 8
`endif
`ifndef BW_AXI_ASIZE
`define BW_AXI_ASIZE 3
`endif
`ifndef BW_AXI_ABURST
`define BW_AXI_ABURST 2
`endif
`ifndef BW_AXI_BRESP
`define BW_AXI_BRESP 2
`endif
`ifndef BW_AXI_RRESP
`define BW_AXI_RRESP 2
`endif
`ifndef BW_AXI_WSTRB
`define BW_AXI_WSTRB(w) ((w)/8)
`endif

interface ervp_axi_sram_responder_if #(
    parameter int BW_ADDR     = 32,
    parameter int BW_AXI_DATA = 32,
    parameter int BW_AXI_TID  = 4
);
    logic [BW_AXI_TID-1:0]                 rxawid;
    logic [BW_ADDR-1:0]                    rxawaddr;
    logic [`BW_AXI_ALEN-1:0]               rxawlen;
    logic [`BW_AXI_ASIZE-1:0]              rxawsize;
    logic [`BW_AXI_ABURST-1:0]             rxawburst;
    logic                                  rxawvalid;
    logic                                  rxawready;
    logic [BW_AXI_TID-1:0]                 rxwid;
    logic [BW_AXI_DATA-1:0]                rxwdata;
    logic [`BW_AXI_WSTRB(BW_AXI_DATA)-1:0] rxwstrb;
    logic                                  rxwlast;
    logic                                  rxwvalid;
    logic                                  rxwready;
    logic [BW_AXI_TID-1:0]                 rxbid;
    logic [`BW_AXI_BRESP-1:0]              rxbresp;
    logic                                  rxbvalid;
    logic                                  rxbready;
    logic [BW_AXI_TID-1:0]                 rxarid;
    logic [BW_ADDR-1:0]                    rxaraddr;
    logic [`BW_AXI_ALEN-1:0]               rxarlen;
    logic [`BW_AXI_ASIZE-1:0]              rxarsize;
    logic [`BW_AXI_ABURST-1:0]             rxarburst;
    logic                                  rxarvalid;
    logic                                  rxarready;
    logic [BW_AXI_TID-1:0]                 rxrid;
    logic [BW_AXI_DATA-1:0]                rxrdata;
    logic [`BW_AXI_RRESP-1:0]              rxrresp;
    logic                                  rxrlast;
    logic                                  rxrvalid;
    logic                                  rxrready;

    modport master (
        output rxawid, rxawaddr, rxawlen, rxawsize, rxawburst, rxawvalid,
        input  rxawready,
        output rxwid, rxwdata, rxwstrb, rxwlast, rxwvalid,
        input  rxwready,
        input  rxbid, rxbresp, rxbvalid,
        output rxbready,
        output rxarid, rxaraddr, rxarlen, rxarsize, rxarburst, rxarvalid,
        input  rxarready,
        input  rxrid, rxrdata, rxrresp, rxrlast, rxrvalid,
        output rxrready
    );

    modport slave (
        input  rxawid, rxawaddr, rxawlen, rxawsize, rxawburst, rxawvalid,
        output rxawready,
        input  rxwid, rxwdata, rxwstrb, rxwlast, rxwvalid,
        output rxwready,
        output rxbid, rxbresp, rxbvalid,
        input  rxbready,
        input  rxarid, rxaraddr, rxarlen, rxarsize, rxarburst, rxarvalid,
        output rxarready,
        output rxrid, rxrdata, rxrresp, rxrlast, rxrvalid,
        input  rxrready
    );
endinterface

`default_nettype wire

// File: rtl/ervp_axi_sram_responder.sv
// ============================================================================
// Module   : ervp_axi_sram_responder
// Purpose  : AXI slave over a word-addressed register array; one write and one
//            read burst in flight concurrently. Optional range checking via
//            ERVP_AXI_SRAM_RESPONDER_RANGE_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef BW_AXI_ALEN
`define BW_AXI_ALEN 8
`endif
`ifndef BW_AXI_ASIZE
`define BW_AXI_ASIZE 3
`endif
`ifndef BW_AXI_ABURST
`define BW_AXI_ABURST 2
`endif

module ervp_axi_sram_responder #(
    parameter int BW_ADDR     = 32,
    parameter int BW_AXI_DATA = 32,
    parameter int BW_AXI_TID  = 4,
    parameter int MEM_DEPTH   = 256
) (
    input  wire logic                  clk,
    input  wire logic                  rstp,
    ervp_axi_sram_responder_if.slave   axi
);
    localparam int NB        = BW_AXI_DATA / 8;
    localparam int LOG_NB    = $clog2(NB);
    localparam int LOG_DEPTH = $clog2(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    logic [BW_AXI_DATA-1:0] mem_q [MEM_DEPTH];

    wstate_t                   w_state_q, w_state_d;
    logic                      awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [BW_AXI_TID-1:0]     wid_q, wid_d;
    logic [BW_ADDR-1:0]        waddr_q, waddr_d;
    logic [`BW_AXI_ALEN-1:0]   wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [`BW_AXI_ASIZE-1:0]  wsize_q, wsize_d;
    logic [`BW_AXI_ABURST-1:0] wburst_q, wburst_d;
    logic                      werr_q, werr_d;

    rstate_t                   r_state_q, r_state_d;
    logic                      arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [BW_AXI_TID-1:0]     rid_q, rid_d;
    logic [BW_ADDR-1:0]        raddr_q, raddr_d;
    logic [`BW_AXI_ALEN-1:0]   rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [`BW_AXI_ASIZE-1:0]  rsize_q, rsize_d;
    logic [`BW_AXI_ABURST-1:0] rburst_q, rburst_d;
    logic [BW_AXI_DATA-1:0]    rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;

    logic                      w_beat, w_wr_en, w_unused_ok;
    logic [BW_ADDR-1:0]        w_rd_addr;
    logic [BW_AXI_DATA-1:0]    w_rd_data;
    logic [1:0]                w_rd_resp;

    // Oversized beats behave as full width; WRAP keeps the address inside its window.
    function automatic logic [BW_ADDR-1:0] f_next_addr(
        input logic [BW_ADDR-1:0]        addr,
        input logic [`BW_AXI_ALEN-1:0]   len,
        input logic [`BW_AXI_ASIZE-1:0]  size,
        input logic [`BW_AXI_ABURST-1:0] burst
    );
        logic [`BW_AXI_ASIZE-1:0] sz;
        logic [BW_ADDR-1:0]       seq, mask;
        sz   = (size > `BW_AXI_ASIZE'(LOG_NB)) ? `BW_AXI_ASIZE'(LOG_NB) : size;
        seq  = addr + (BW_ADDR'(1) << sz);
        mask = ((BW_ADDR'(len) + BW_ADDR'(1)) << sz) - BW_ADDR'(1);
        case (burst)
            2'b00:   f_next_addr = addr;
            2'b10:   f_next_addr = (addr & ~mask) | (seq & mask);
            default: f_next_addr = seq;
        endcase
    endfunction

`ifdef ERVP_AXI_SRAM_RESPONDER_RANGE_CHECK_EN
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         OOR_LSB     = LOG_NB + LOG_DEPTH;
    function automatic logic f_oor(input logic [BW_ADDR-1:0] addr);
        return |(addr >> OOR_LSB);
    endfunction
`endif

    assign w_beat = (w_state_q == W_DATA) && axi.rxwvalid && wready_q;
`ifdef ERVP_AXI_SRAM_RESPONDER_RANGE_CHECK_EN
    assign w_wr_en = w_beat && !f_oor(waddr_q);
`else
    assign w_wr_en = w_beat;
`endif

    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        wid_d     = wid_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wcnt_d    = wcnt_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        werr_d    = werr_q;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (axi.rxawvalid && awready_q) begin
                    wid_d     = axi.rxawid;
                    waddr_d   = axi.rxawaddr;
                    wlen_d    = axi.rxawlen;
                    wsize_d   = axi.rxawsize;
                    wburst_d  = axi.rxawburst;
                    wcnt_d    = '0;
                    werr_d    = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_beat) begin
                    waddr_d = f_next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                    wcnt_d  = wcnt_q + 1'b1;
`ifdef ERVP_AXI_SRAM_RESPONDER_RANGE_CHECK_EN
                    if (f_oor(waddr_q) || (axi.rxwlast != (wcnt_q == wlen_q)))
                        werr_d = 1'b1;
`endif
                    if (wcnt_q == wlen_q) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (axi.rxbready && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // The array is read combinationally and written here, so a same-cycle read sees old data.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (axi.rxwstrb[b])
                    mem_q[waddr_q[LOG_NB +: LOG_DEPTH]][8*b +: 8] <= axi.rxwdata[8*b +: 8];
            end
        end
    end

    assign w_rd_addr = (r_state_q == R_IDLE) ? axi.rxaraddr
                                             : f_next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
`ifdef ERVP_AXI_SRAM_RESPONDER_RANGE_CHECK_EN
    assign w_rd_data = f_oor(w_rd_addr) ? '0 : mem_q[w_rd_addr[LOG_NB +: LOG_DEPTH]];
    assign w_rd_resp = f_oor(w_rd_addr) ? RESP_SLVERR : RESP_OKAY;
`else
    assign w_rd_data = mem_q[w_rd_addr[LOG_NB +: LOG_DEPTH]];
    assign w_rd_resp = RESP_OKAY;
`endif

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (axi.rxarvalid && arready_q) begin
                    rid_d     = axi.rxarid;
                    raddr_d   = axi.rxaraddr;
                    rlen_d    = axi.rxarlen;
                    rsize_d   = axi.rxarsize;
                    rburst_d  = axi.rxarburst;
                    rcnt_d    = '0;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rlast_d   = (axi.rxarlen == '0);
                    rdata_d   = w_rd_data;
                    rresp_d   = w_rd_resp;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (axi.rxrready && rvalid_q) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        raddr_d = w_rd_addr;
                        rcnt_d  = rcnt_q + 1'b1;
                        rlast_d = ((rcnt_q + 1'b1) == rlen_q);
                        rdata_d = w_rd_data;
                        rresp_d = w_rd_resp;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            werr_q    <= 1'b0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            wid_q     <= wid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            werr_q    <= werr_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign axi.rxawready = awready_q;
    assign axi.rxwready  = wready_q;
    assign axi.rxbvalid  = bvalid_q;
    assign axi.rxbid     = wid_q;
`ifdef ERVP_AXI_SRAM_RESPONDER_RANGE_CHECK_EN
    assign axi.rxbresp   = werr_q ? RESP_SLVERR : RESP_OKAY;
`else
    assign axi.rxbresp   = RESP_OKAY;
`endif
    assign axi.rxarready = arready_q;
    assign axi.rxrvalid  = rvalid_q;
    assign axi.rxrlast   = rlast_q;
    assign axi.rxrid     = rid_q;
    assign axi.rxrdata   = rdata_q;
    assign axi.rxrresp   = rresp_q;

    assign w_unused_ok = ^{axi.rxwid, axi.rxwlast};

endmodule

`default_nettype wire

// File: tb/tb_ervp_axi_sram_responder.sv
// ============================================================================
// Module   : tb_ervp_axi_sram_responder
// Purpose  : Randomized bench for the AXI SRAM responder against a byte-array model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ervp_axi_sram_responder;
    localparam int BW_ADDR = 32, BW_AXI_DATA = 32, BW_AXI_TID = 4, MEM_DEPTH = 256;
    localparam int MEM_BYTES = MEM_DEPTH * 4;
    localparam int TMO = 50;

    logic clk = 1'b0;
    logic rstp = 1'b0;
    always #5 clk = ~clk;

    ervp_axi_sram_responder_if #(.BW_ADDR(BW_ADDR), .BW_AXI_DATA(BW_AXI_DATA),
                                 .BW_AXI_TID(BW_AXI_TID)) axi_if ();

    ervp_axi_sram_responder #(.BW_ADDR(BW_ADDR), .BW_AXI_DATA(BW_AXI_DATA),
                              .BW_AXI_TID(BW_AXI_TID), .MEM_DEPTH(MEM_DEPTH)) u_dut (
        .clk  (clk),
        .rstp (rstp),
        .axi  (axi_if)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  ref_mem [MEM_BYTES];
    logic [31:0] dq[$];
    logic [3:0]  sq[$];
    logic [31:0] obs[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    // Byte address of beat i from the burst rules, computed from scratch each time.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input int size, input int burst, input int i);
        logic [31:0] nb, total, base;
        nb = 32'd1 << ((size > 2) ? 2 : size);
        case (burst)
            0: return start;
            2: begin
                total = 32'(len + 1) * nb;
                base  = start - (start % total);
                return base + ((start - base + 32'(i) * nb) % total);
            end
            default: return start + 32'(i) * nb;
        endcase
    endfunction

    function automatic bit in_range(input logic [31:0] a);
`ifdef ERVP_AXI_SRAM_RESPONDER_RANGE_CHECK_EN
        return a < 32'(MEM_BYTES);
`else
        return (a != 32'hFFFF_FFFF) || 1'b1;
`endif
    endfunction

    function automatic int word_base(input logic [31:0] a);
        return int'(a & 32'(MEM_BYTES - 4));
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (in_range(a))
            for (int j = 0; j < 4; j++)
                if (s[j]) ref_mem[word_base(a) + j] = d[8*j +: 8];
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int b;
        if (!in_range(a)) return 32'h0;
        b = word_base(a);
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_aw_w_b"}, {axi_if.rxawready, axi_if.rxwready, axi_if.rxbvalid,
                                 axi_if.rxbid, axi_if.rxbresp}, 0);
        check({tag, "_ar_r"}, {axi_if.rxarready, axi_if.rxrvalid, axi_if.rxrlast,
                               axi_if.rxrid, axi_if.rxrresp}, 0);
        check({tag, "_rdata"}, axi_if.rxrdata, 0);
    endtask

    // Beat abort_at (if >= 0) is interrupted by an asynchronous reset.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int size, input int burst, input int bhold, input int abort_at);
        int t;
        bit err;
        logic [31:0] a;
        err = 0;
        @(negedge clk);
        axi_if.rxawid = id;  axi_if.rxawaddr = addr;  axi_if.rxawlen = len[7:0];
        axi_if.rxawsize = size[2:0];  axi_if.rxawburst = burst[1:0];  axi_if.rxawvalid = 1'b1;
        t = 0;
        while (!axi_if.rxawready && t < TMO) begin @(negedge clk); t++; end
        check("aw_accept", axi_if.rxawready, 1);
        @(negedge clk);
        axi_if.rxawvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (i == abort_at) begin
                #2 rstp = 1'b1;
                #1 check_reset_outputs("async_reset");
                axi_if.rxwvalid = 1'b0;
                @(negedge clk);
                rstp = 1'b0;
                #1 check("awready_low_at_release", axi_if.rxawready, 0);
                @(posedge clk);
                #1 check("awready_first_edge", {axi_if.rxawready, axi_if.rxarready}, 2'b11);
                return;
            end
            if ($urandom_range(0, 3) == 0) begin axi_if.rxwvalid = 1'b0; @(negedge clk); end
            axi_if.rxwdata = dq[i];  axi_if.rxwstrb = sq[i];
            axi_if.rxwlast = (i == len);  axi_if.rxwvalid = 1'b1;
            t = 0;
            while (!axi_if.rxwready && t < TMO) begin @(negedge clk); t++; end
            check("w_accept", axi_if.rxwready, 1);
            a = beat_addr(addr, len, size, burst, i);
            if (!in_range(a)) err = 1;
            model_write(a, dq[i], sq[i]);
            @(negedge clk);
        end
        axi_if.rxwvalid = 1'b0;  axi_if.rxwlast = 1'b0;
        t = 0;
        while (!axi_if.rxbvalid && t < TMO) begin @(negedge clk); t++; end
        check("b_valid", axi_if.rxbvalid, 1);
        check("w_ready_dropped", axi_if.rxwready, 0);
        for (int k = 0; k < bhold; k++) begin
            @(negedge clk);
            check("b_hold", {axi_if.rxbvalid, axi_if.rxbid, axi_if.rxbresp},
                  {1'b1, id, err ? 2'b10 : 2'b00});
            check("aw_blocked", axi_if.rxawready, 0);
        end
        check("b_id", axi_if.rxbid, id);
        check("b_resp", axi_if.rxbresp, err ? 2'b10 : 2'b00);
        axi_if.rxbready = 1'b1;
        @(negedge clk);
        axi_if.rxbready = 1'b0;
        check("b_done", axi_if.rxbvalid, 0);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int stall_beat, input int stall_len);
        int t, stall;
        logic [31:0] a, exp;
        obs = {};
        @(negedge clk);
        axi_if.rxarid = id;  axi_if.rxaraddr = addr;  axi_if.rxarlen = len[7:0];
        axi_if.rxarsize = size[2:0];  axi_if.rxarburst = burst[1:0];  axi_if.rxarvalid = 1'b1;
        t = 0;
        while (!axi_if.rxarready && t < TMO) begin @(negedge clk); t++; end
        check("ar_accept", axi_if.rxarready, 1);
        @(negedge clk);
        axi_if.rxarvalid = 1'b0;
        check("r_latency", axi_if.rxrvalid, 1);
        for (int i = 0; i <= len; i++) begin
            a   = beat_addr(addr, len, size, burst, i);
            exp = model_read(a);
            t = 0;
            while (!axi_if.rxrvalid && t < TMO) begin @(negedge clk); t++; end
            stall = (i == stall_beat) ? stall_len : int'($urandom_range(0, 1));
            axi_if.rxrready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check("r_stall", {axi_if.rxrvalid, axi_if.rxrdata, axi_if.rxrlast, axi_if.rxrid},
                      {1'b1, exp, i == len, id});
            end
            axi_if.rxrready = 1'b1;
            check("r_valid", axi_if.rxrvalid, 1);
            check("r_data", axi_if.rxrdata, exp);
            check("r_id_last_resp", {axi_if.rxrid, axi_if.rxrlast, axi_if.rxrresp},
                  {id, i == len, in_range(a) ? 2'b00 : 2'b10});
            obs.push_back(axi_if.rxrdata);
            @(negedge clk);
        end
        axi_if.rxrready = 1'b0;
        check("r_done", {axi_if.rxrvalid, axi_if.rxarready}, 2'b01);
    endtask

    task automatic fill(input logic [31:0] d0, input int n, input logic [3:0] s);
        dq = {};  sq = {};
        for (int i = 0; i < n; i++) begin dq.push_back(d0 + 32'(i)); sq.push_back(s); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        int len, size, burst;
        logic [31:0] addr;
        axi_if.rxawid = '0;  axi_if.rxawaddr = '0;  axi_if.rxawlen = '0;  axi_if.rxawsize = '0;
        axi_if.rxawburst = '0;  axi_if.rxawvalid = 1'b0;  axi_if.rxwid = '0;  axi_if.rxwdata = '0;
        axi_if.rxwstrb = '0;  axi_if.rxwlast = 1'b0;  axi_if.rxwvalid = 1'b0;  axi_if.rxbready = 1'b0;
        axi_if.rxarid = '0;  axi_if.rxaraddr = '0;  axi_if.rxarlen = '0;  axi_if.rxarsize = '0;
        axi_if.rxarburst = '0;  axi_if.rxarvalid = 1'b0;  axi_if.rxrready = 1'b0;

        #1 rstp = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstp = 1'b0;
        #1 check("ready_low_at_release", {axi_if.rxawready, axi_if.rxarready}, 2'b00);
        @(posedge clk);
        #1 check("ready_after_release", {axi_if.rxawready, axi_if.rxarready}, 2'b11);

        dq = {};  sq = {};
        for (int i = 0; i < MEM_DEPTH; i++) begin dq.push_back($urandom); sq.push_back(4'hF); end
        do_write(4'h1, 32'h0, MEM_DEPTH - 1, 2, 1, 0, -1);

        fill(32'hA0, 4, 4'hF);
        do_write(4'h5, 32'h10, 3, 2, 1, 0, -1);
        do_read(4'h6, 32'h10, 3, 2, 1, -1, 0);
        check("incr_readback", {obs[0], obs[1], obs[2], obs[3]}, {32'hA0, 32'hA1, 32'hA2, 32'hA3});

        dq = '{32'hFFFF_FFFF, 32'h1122_3344};  sq = '{4'hF, 4'h5};
        do_write(4'h2, 32'h30, 1, 2, 0, 0, -1);
        do_read(4'h3, 32'h30, 0, 2, 1, -1, 0);
        check("partial_strobe", obs[0], 32'hFF22_FF44);

        fill(32'hB0, 4, 4'hF);
        do_write(4'h7, 32'h00, 3, 2, 1, 0, -1);
        do_read(4'h8, 32'h08, 3, 2, 2, -1, 0);
        check("wrap_order", {obs[0], obs[1], obs[2], obs[3]}, {32'hB2, 32'hB3, 32'hB0, 32'hB1});

        dq = '{32'hC0FF_EE00};  sq = '{4'hF};
        do_write(4'h9, 32'h20, 0, 2, 1, 0, -1);
        do_read(4'hA, 32'h20, 3, 2, 0, -1, 0);
        check("fixed_repeat", {obs[0], obs[1], obs[2], obs[3]},
              {32'hC0FF_EE00, 32'hC0FF_EE00, 32'hC0FF_EE00, 32'hC0FF_EE00});

        fill(32'hD000, 8, 4'hF);
        do_write(4'hB, 32'h40, 7, 2, 1, 3, -1);
        do_read(4'hC, 32'h40, 7, 2, 1, 3, 5);
        check("stall_no_lost_beat", {obs.size(), obs[7]}, {32'd8, 32'hD007});

        fill(32'hE000, 8, 4'hF);
        do_write(4'hD, 32'h80, 7, 2, 1, 0, 2);
        fill(32'hF000, 2, 4'hF);
        do_write(4'hE, 32'h84, 1, 2, 1, 0, -1);
        do_read(4'hF, 32'h80, 3, 2, 1, -1, 0);
        check("after_reset_burst", {obs[0], obs[1], obs[2]}, {32'hE000, 32'hF000, 32'hF001});

`ifdef ERVP_AXI_SRAM_RESPONDER_RANGE_CHECK_EN
        do_read(4'h1, 32'h3FC, 1, 2, 1, -1, 0);
        check("oor_read_beat1_zero", obs[1], 32'h0);
        dq = '{32'h5A5A_5A5A};  sq = '{4'hF};
        do_write(4'h2, 32'h400, 0, 2, 1, 0, -1);
        do_read(4'h3, 32'h000, 0, 2, 1, -1, 0);
        check("oor_write_no_alias", obs[0], 32'hB0);
`else
        dq = '{32'h1234_5678};  sq = '{4'hF};
        do_write(4'h2, 32'h1044, 0, 2, 1, 0, -1);
        do_read(4'h3, 32'h44, 0, 2, 1, -1, 0);
        check("addr_wraps_modulo", obs[0], 32'h1234_5678);
`endif

        for (int it = 0; it < 40; it++) begin
            burst = int'($urandom_range(0, 3));
            size  = int'($urandom_range(0, 3));
            len   = (burst == 2) ? (2 << $urandom_range(0, 3)) - 1 : int'($urandom_range(0, 15));
            addr  = 32'($urandom_range(0, 32'h2FF));
            if (it % 2 == 0) begin
                dq = {};  sq = {};
                for (int i = 0; i <= len; i++) begin
                    dq.push_back($urandom);  sq.push_back(4'($urandom_range(0, 15)));
                end
                do_write(4'($urandom), addr, len, size, burst, int'($urandom_range(0, 2)), -1);
            end else begin
                do_read(4'($urandom), addr, len, size, burst, -1, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/ervp_axi_sram_responder.md
Name: ervp_axi_sram_responder

Overview:
- AXI slave backed by a word-addressed register-array memory; the responder end of the AXI master port that the DMA engine drives.
- Accepts AW/W/B and AR/R bursts and services one write burst and one read burst concurrently.
- Used as a local scratch memory and as the DMA target model in subsystem benches.

Parameters:
BW_ADDR, 32, AXI address width
BW_AXI_DATA, 32, data width; power of two, >= 8
BW_AXI_TID, 4, transaction ID width
MEM_DEPTH, 256, number of BW_AXI_DATA-wide words; power of two

Ports:
clk  input  1  single clock
rstp  input  1  asynchronous reset, active-high
rxawid  input  BW_AXI_TID  write ID
rxawaddr  input  BW_ADDR  write start byte address
rxawlen  input  `BW_AXI_ALEN  beats-1
rxawsize  input  `BW_AXI_ASIZE  log2 bytes per beat
rxawburst  input  `BW_AXI_ABURST  00 FIXED, 01 INCR, 10 WRAP
rxawvalid  input  1  AW valid
rxawready  output  1  AW ready
rxwid  input  BW_AXI_TID  ignored
rxwdata  input  BW_AXI_DATA  write data
rxwstrb  input  `BW_AXI_WSTRB(BW_AXI_DATA)  byte enables
rxwlast  input  1  last beat flag
rxwvalid  input  1  W valid
rxwready  output  1  W ready
rxbid  output  BW_AXI_TID  response ID
rxbresp  output  `BW_AXI_BRESP  write response
rxbvalid  output  1  B valid
rxbready  input  1  B ready
rxarid, rxaraddr, rxarlen, rxarsize, rxarburst, rxarvalid  input  as AW  read address channel
rxarready  output  1  AR ready
rxrid  output  BW_AXI_TID  read ID
rxrdata  output  BW_AXI_DATA  read data
rxrresp  output  `BW_AXI_RRESP  read response
rxrlast  output  1  last read beat
rxrvalid  output  1  R valid
rxrready  input  1  R ready

Behaviour:
- Reset (rstp high, async): all outputs 0, both FSMs in IDLE, memory contents not reset. rxawready and rxarready are registered; they first rise on the first clk edge after rstp falls.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: rxawready=1. On AW handshake, capture id, addr, len, size, burst; clear beat count; next cycle enter W_DATA with rxawready=0 and rxwready=1.
  - W_DATA: on each W handshake, write bytes whose wstrb bit is 1 to word addr[log2(BW_AXI_DATA/8) +: log2(MEM_DEPTH)]; this index wraps modulo MEM_DEPTH. After beat len+1, drop rxwready and go to W_RESP. Beat completion uses the count only; rxwlast is not checked.
  - W_RESP: rxbvalid=1, rxbid=captured id, rxbresp=OKAY. Hold all B signals until rxbready, then return to W_IDLE.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: rxarready=1. On AR handshake, capture fields.
  - Read latency: rxrvalid rises 1 cycle after the AR handshake, carrying the first word.
  - R_DATA: rxrdata, rxrid and rxrlast stay stable while rxrvalid=1 and rxrready=0. On each R handshake, advance the address and present the next beat in the following cycle (1 beat/cycle under continuous ready). rxrlast=1 on beat len+1. That handshake returns the FSM to R_IDLE; rxarready is 1 again in the next cycle. rxrresp=OKAY.
- Address advance: next = addr + (1<<size).
  - FIXED: address holds.
  - WRAP: wraps inside the aligned window of (len+1)<<size bytes.
  - Burst type 11: treated as INCR.
  - size > log2(BW_AXI_DATA/8): treated as full width.
- Simultaneous write and read to the same word in the same cycle: the read returns old data and the write completes.
- Write and read channels are independent; no ordering is enforced between them.

Optional Feature:
ERVP_AXI_SRAM_RESPONDER_RANGE_CHECK_EN:
- Defined:
  - Any beat whose byte address >= MEM_DEPTH*(BW_AXI_DATA/8) is out of range.
  - Out-of-range write beats are discarded; a sticky flag makes rxbresp=SLVERR (2'b10) for the whole burst.
  - Out-of-range read beats return rxrdata=0 with rxrresp=SLVERR; in-range beats return OKAY.
  - If rxwlast does not match the final counted beat, rxbresp=SLVERR.
- Undefined: addresses wrap modulo the memory size, and every response is OKAY.

Test Plan:
- INCR write, len=3, size=2, addr 0x10, data 0xA0..0xA3, wstrb 0xF -> rxbvalid with bid = awid and OKAY. INCR read of the same range returns 0xA0..0xA3 with rxrlast on the 4th beat and rxrvalid 1 cycle after the AR handshake.
- Partial-strobe write of 0x11223344 with wstrb=0x5 over a word holding 0xFFFFFFFF -> readback 0xFF22FF44.
- WRAP read, len=3, size=2, addr 0x08 -> beat addresses 0x08, 0x0C, 0x00, 0x04. FIXED read of 4 beats at 0x20 -> the same word 4 times.
- Hold rxrready=0 for 5 cycles mid-burst, and hold rxbready=0 for 3 cycles -> data, id, last and resp stay stable with no lost beat. The next AW is not accepted until the B handshake.
- Assert rstp during beat 2 of an 8-beat write -> all outputs 0 immediately. rxawready=1 on the first edge after release, and a new burst completes normally.
- With the range-check macro defined and MEM_DEPTH=256, 32-bit data: read at 0x3FC, len=1 -> beat0 OKAY, beat1 rdata 0 with SLVERR. Write at 0x400 -> rxbresp=SLVERR and memory is unchanged.
